// File: rtl/multu_hilo_ctrl.sv
// Shift-add sequencer for unsigned multiply with the HI/LO register pair.
// One partial-product step per cycle; HI/LO are written only when a multiply completes.
module multu_hilo_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   product, mcand, sum;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic                 accept, last_step;

  // A new multiply can be taken in IDLE or in the DONE cycle (back-to-back issue).
  always_comb begin
    accept     = start & ~flush & (state != BUSY);
    last_step  = (cnt == LAST_CNT);
    sum        = product + (mplier[0] ? mcand : '0);
    state_nxt  = state;
    busy       = (state == BUSY);
    done       = (state == DONE);
    stall      = busy & (start | rd_hi | rd_lo) & ~flush;
    hilo_rdata = rd_hi ? hi : lo;

    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY: begin
        if (flush)          state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE:    state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (accept) begin
      mcand   <= {{WIDTH{1'b0}}, opa};
      mplier  <= opb;
      product <= '0;
      cnt     <= '0;
    end else if (busy && !flush) begin
      // A flushed multiply stops here, so HI/LO never see a squashed result.
      product <= sum;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt + CNT_W'(1);
      if (last_step) {hi, lo} <= sum;
    end
  end

endmodule
